// File: rtl/mem_access_pkg.sv
// common: shared types for the RV32 pipeline.
//   mem_size_t  - load/store access width
//   mem_state_t - memory-access stage FSM states
// Helper functions decode misalignment and build the store-side bus lanes,
// so the top level stays a plain FSM plus datapath registers.
package common;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic [31:0] FULL_MASK = 32'hFFFF_FFFF;

  // Bytes never misalign; halves need addr[0]=0; words need addr[1:0]=0.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
    case (size)
      MEM_HALF: is_misaligned = offset[0];
      MEM_WORD: is_misaligned = |offset;
      default:  is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input mem_size_t size, input logic [1:0] offset);
    case (size)
      MEM_BYTE: store_strb = 4'b0001 << offset;
      MEM_HALF: store_strb = offset[1] ? 4'b1100 : 4'b0011;
      default:  store_strb = 4'b1111;
    endcase
  endfunction

  // Data is replicated across lanes so the strobes alone pick the target bytes.
  function automatic logic [31:0] store_wdata(input mem_size_t size, input logic [31:0] data);
    case (size)
      MEM_BYTE: store_wdata = {4{data[7:0]}};
      MEM_HALF: store_wdata = {2{data[15:0]}};
      default:  store_wdata = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: combinational load-data aligner.
//   rdata       - raw bus word
//   offset      - byte offset of the access within the word
//   size        - access width
//   is_unsigned - zero-extend (LBU/LHU) instead of sign-extend
//   data        - selected lane shifted to bit 0, extended
//   mask        - write-back mask applied by write_back
// Kept stand-alone so a future cache-hit path can reuse it.
module load_align
  import common::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] data,
  output logic [31:0] mask
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: every output gets a default first, so no path through the case
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    data = rdata;
    mask = FULL_MASK;
    case (size)
      MEM_BYTE: begin
        if (is_unsigned) begin
          data = {24'h0, byte_sel};
          mask = 32'h0000_00FF;
        end else begin
          data = {{24{byte_sel[7]}}, byte_sel};
        end
      end
      MEM_HALF: begin
        if (is_unsigned) begin
          data = {16'h0, half_sel};
          mask = 32'h0000_FFFF;
        end else begin
          data = {{16{half_sel[15]}}, half_sel};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: RV32 memory-access stage between execute and write_back.
// Accepts one load/store from execute, runs a single request/grant plus
// response transaction on the data bus, and stalls upstream until done.
//   clk, rst            - clock, synchronous active-high reset
//   ex_valid ... store_data - operation from execute (held while stall=1)
//   stall               - freeze upstream stages
//   done, misaligned    - one-cycle completion pulse / misaligned flag
//   read_data, wb_mask  - aligned load data and write-back mask
//   dbus_*              - data bus request, write fields and response
module mem_access
  import common::*;
#(
  parameter logic [31:0] RESET_DATA = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_we,
  input  mem_size_t   mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] read_data,
  output logic [31:0] wb_mask,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_strb,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  mem_state_t  state_q, state_d;
  logic        we_q;
  mem_size_t   size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic        mis_q;
  logic [31:0] align_data;
  logic [31:0] align_mask;

  logic accept;
  assign accept = (state_q == IDLE) && ex_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ex_valid) state_d = is_misaligned(mem_size, addr[1:0]) ? DONE : REQ;
      // Only the grant matters here; a simultaneous rvalid is not ours yet.
      REQ:  if (dbus_gnt) state_d = RESP;
      RESP: if (dbus_rvalid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= MEM_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= 32'h0;
      sdata_q   <= 32'h0;
      mis_q     <= 1'b0;
      read_data <= RESET_DATA;
      wb_mask   <= FULL_MASK;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= mem_we;
        size_q  <= mem_size;
        uns_q   <= mem_unsigned;
        addr_q  <= addr;
        sdata_q <= store_data;
        mis_q   <= is_misaligned(mem_size, addr[1:0]);
      end
      if ((state_q == RESP) && dbus_rvalid && !we_q) begin
        read_data <= align_data;
        wb_mask   <= align_mask;
      end
    end
  end

  load_align u_load_align (
    .rdata       (dbus_rdata),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (align_data),
    .mask        (align_mask)
  );

  // Bus fields are decoded from state and latched fields only, so nothing
  // reaches the bus combinationally from execute.
  assign dbus_req   = (state_q == REQ);
  assign dbus_we    = dbus_req && we_q;
  assign dbus_addr  = {addr_q[31:2], 2'b00};
  assign dbus_strb  = dbus_we ? store_strb(size_q, addr_q[1:0]) : 4'b0000;
  assign dbus_wdata = dbus_we ? store_wdata(size_q, sdata_q) : 32'h0;

  assign done       = (state_q == DONE);
  assign misaligned = done && mis_q;
  assign stall      = ex_valid && !done;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import common::*;

  localparam logic [31:0] RST_VAL = 32'hCAFE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        mem_we;
  mem_size_t   mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic        misaligned;
  logic [31:0] read_data;
  logic [31:0] wb_mask;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_strb;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;

  mem_access #(.RESET_DATA(RST_VAL)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .store_data   (store_data),
    .stall        (stall),
    .done         (done),
    .misaligned   (misaligned),
    .read_data    (read_data),
    .wb_mask      (wb_mask),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_wdata   (dbus_wdata),
    .dbus_strb    (dbus_strb),
    .dbus_gnt     (dbus_gnt),
    .dbus_rvalid  (dbus_rvalid),
    .dbus_rdata   (dbus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mis;
    logic [31:0] rd;
    logic [31:0] mask;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  int          n_push   = 0;
  logic [31:0] last_rd   = RST_VAL;
  logic [31:0] last_mask = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no completion (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("mon_misaligned", {31'h0, misaligned}, {31'h0, e.mis});
          check("mon_read_data", read_data, e.rd);
          check("mon_wb_mask", wb_mask, e.mask);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic do_op(input string name, input logic we, input mem_size_t size,
                       input logic uns, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                       input logic rv_with_gnt, input logic exp_mis,
                       input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rd, input logic [31:0] exp_mask);
    exp_t e;
    tick();
    ex_valid = 1'b1; mem_we = we; mem_size = size; mem_unsigned = uns;
    addr = a; store_data = sd;
    e.mis = exp_mis;
    if (!we && !exp_mis) begin
      last_rd = exp_rd;
      last_mask = exp_mask;
    end
    e.rd = last_rd;
    e.mask = last_mask;
    sb_q.push_back(e);
    n_push++;
    @(negedge clk);
    check({name, "_c0_stall"}, {31'h0, stall}, 32'h1);
    check({name, "_c0_req"}, {31'h0, dbus_req}, 32'h0);
    tick();
    if (exp_mis) begin
      @(negedge clk);
      check({name, "_mis_done"}, {31'h0, done}, 32'h1);
      check({name, "_mis_req"}, {31'h0, dbus_req}, 32'h0);
      check({name, "_mis_strb"}, {28'h0, dbus_strb}, 32'h0);
      check({name, "_mis_stall"}, {31'h0, stall}, 32'h0);
      tick();
      ex_valid = 1'b0;
      @(negedge clk);
      check({name, "_mis_done_drop"}, {31'h0, done}, 32'h0);
      return;
    end
    for (int g = 0; g <= gnt_dly; g++) begin
      dbus_gnt = (g == gnt_dly);
      dbus_rvalid = rv_with_gnt && (g == gnt_dly);
      dbus_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      check({name, "_req"}, {31'h0, dbus_req}, 32'h1);
      check({name, "_addr"}, dbus_addr, {a[31:2], 2'b00});
      check({name, "_we"}, {31'h0, dbus_we}, {31'h0, we});
      check({name, "_strb"}, {28'h0, dbus_strb}, {28'h0, exp_strb});
      check({name, "_wdata"}, dbus_wdata, exp_wdata);
      check({name, "_req_stall"}, {31'h0, stall}, 32'h1);
      check({name, "_req_done"}, {31'h0, done}, 32'h0);
      tick();
    end
    dbus_gnt = 1'b0;
    for (int r = 0; r <= rv_dly; r++) begin
      dbus_rvalid = (r == rv_dly);
      dbus_rdata = (r == rv_dly) ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      check({name, "_resp_req"}, {31'h0, dbus_req}, 32'h0);
      check({name, "_resp_stall"}, {31'h0, stall}, 32'h1);
      check({name, "_resp_done"}, {31'h0, done}, 32'h0);
      tick();
    end
    dbus_rvalid = 1'b0;
    dbus_rdata = 32'h0;
    @(negedge clk);
    check({name, "_done"}, {31'h0, done}, 32'h1);
    check({name, "_done_stall"}, {31'h0, stall}, 32'h0);
    tick();
    ex_valid = 1'b0;
    @(negedge clk);
    check({name, "_done_drop"}, {31'h0, done}, 32'h0);
    check({name, "_idle_req"}, {31'h0, dbus_req}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; mem_we = 1'b0; mem_size = MEM_WORD;
    mem_unsigned = 1'b0; addr = 32'h0; store_data = 32'h0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
    tick();
    tick();
    rst = 1'b0;
    tick();
    dbus_rvalid = 1'b0;
    @(negedge clk);
    check("rst_req", {31'h0, dbus_req}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_read_data", read_data, RST_VAL);
    check("rst_wb_mask", wb_mask, 32'hFFFF_FFFF);
    check("rst_strb", {28'h0, dbus_strb}, 32'h0);
    check("rst_wdata", dbus_wdata, 32'h0);
    check("rst_addr", dbus_addr, 32'h0);

    //    name   we    size      uns   addr          store_data    rdata         g  r  rvg   mis   strb     wdata         rd            mask
    do_op("lw",  1'b0, MEM_WORD, 1'b0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 32'hFFFF_FFFF);
    do_op("lb",  1'b0, MEM_BYTE, 1'b0, 32'h0000_1003, 32'h0,        32'h8011_2233, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80, 32'hFFFF_FFFF);
    do_op("lbu", 1'b0, MEM_BYTE, 1'b1, 32'h0000_1003, 32'h0,        32'h8011_2233, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0080, 32'h0000_00FF);
    do_op("sh",  1'b1, MEM_HALF, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        0, 1, 1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0,        32'h0);
    do_op("lwm", 1'b0, MEM_WORD, 1'b0, 32'h0000_1002, 32'h0,        32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,         32'h0);
    do_op("sb",  1'b1, MEM_BYTE, 1'b0, 32'h0000_3001, 32'h0000_00A5, 32'h0,        3, 2, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        32'h0);
    do_op("lh",  1'b0, MEM_HALF, 1'b0, 32'h0000_1002, 32'h0,        32'h8011_2233, 0, 1, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8011, 32'hFFFF_FFFF);
    do_op("lhu", 1'b0, MEM_HALF, 1'b1, 32'h0000_1000, 32'h0,        32'h8011_2233, 1, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_2233, 32'h0000_FFFF);
    do_op("lb1", 1'b0, MEM_BYTE, 1'b0, 32'h0000_1001, 32'h0,        32'h8011_2233, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0022, 32'hFFFF_FFFF);
    do_op("sw",  1'b1, MEM_WORD, 1'b0, 32'h0000_4000, 32'h1234_5678, 32'h0,        1, 0, 1'b0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0,        32'h0);
    do_op("lhm", 1'b0, MEM_HALF, 1'b0, 32'h0000_1001, 32'h0,        32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,         32'h0);
    do_op("shm", 1'b1, MEM_HALF, 1'b0, 32'h0000_2001, 32'h0000_ABCD, 32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,         32'h0);

    // Reset while waiting for the response, then a late response arrives.
    tick();
    ex_valid = 1'b1; mem_we = 1'b0; mem_size = MEM_WORD; mem_unsigned = 1'b0;
    addr = 32'h0000_1000; store_data = 32'h0;
    tick();
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    @(negedge clk);
    check("rstx_resp_req", {31'h0, dbus_req}, 32'h0);
    tick();
    rst = 1'b1;
    ex_valid = 1'b0;
    tick();
    rst = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rstx_req", {31'h0, dbus_req}, 32'h0);
    check("rstx_done", {31'h0, done}, 32'h0);
    check("rstx_read_data", read_data, RST_VAL);
    check("rstx_wb_mask", wb_mask, 32'hFFFF_FFFF);
    tick();
    dbus_rvalid = 1'b0;
    @(negedge clk);
    check("rstx_late_done", {31'h0, done}, 32'h0);
    check("rstx_late_read_data", read_data, RST_VAL);
    last_rd = RST_VAL;
    last_mask = 32'hFFFF_FFFF;

    do_op("lbu0", 1'b0, MEM_BYTE, 1'b1, 32'h0000_1000, 32'h0,       32'h8011_2233, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0033, 32'h0000_00FF);

    tick();
    tick();
    check("done_count", n_done, n_push);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
